weight_bank_streamer: RTL and testbench

// Parametrised, banked weight memory with a burst-fetch streaming read port for the DS-CNN

---
 rtl/weight_bank_streamer.sv | 161 ++++++++++++++++
 tb/tb_weight_bank_streamer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/weight_bank_streamer.sv
// Banked weight memory with a burst-fetch streaming read port.
// NUM_BANKS synchronous-read banks form one address space. A request (base, len)
// streams len consecutive words over valid/ready through a 2-entry skid FIFO.
module weight_bank_streamer #(
   parameter int DATA_W     = 8,
   parameter int BANK_DEPTH = 512,
   parameter int NUM_BANKS  = 9,
   parameter int DEPTH      = 4296,
   parameter int ADDR_W     = 13,
   parameter int LEN_W      = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_base,
   input  logic [LEN_W-1:0]  req_len,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              done,
   output logic              err,
   output logic              busy,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int ROW_W  = $clog2(BANK_DEPTH);
   localparam int BANK_W = ADDR_W - ROW_W;
   localparam int SUM_W  = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   rd_addr_q;
   logic [LEN_W-1:0]    rd_left_q;
   logic                done_q, err_q;
   logic [BANK_W-1:0]   rd_sel_q, rd_sel_d;
   logic                infl_q, infl_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                wptr_q, wptr_d, rptr_q, rptr_d;
   logic [DATA_W-1:0]   fifo_q [2];
   logic [DATA_W-1:0]   bank_rd [NUM_BANKS];
   logic [DATA_W-1:0]   bank_data;
   logic [2:0]          held;
   logic                issue, pop, push, fifo_pop, last_hs, wr_ok, over;

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign err       = err_q;

   // Handshake, issue throttle and write qualification.
   // The word returning from the banks this cycle (infl_q) counts as output
   // storage, so a word can leave one cycle after it is read.
   always_comb begin
      held      = {1'b0, cnt_q} + {2'b0, infl_q};
      issue     = (state_q == S_FETCH) && (held < 3'd2);
      out_valid = (cnt_q != 2'd0) || infl_q;
      out_data  = (cnt_q != 2'd0) ? fifo_q[rptr_q] : bank_data;
      pop       = out_valid && out_ready;
      fifo_pop  = pop && (cnt_q != 2'd0);
      push      = infl_q && !(pop && (cnt_q == 2'd0));
      last_hs   = (state_q == S_DRAIN) && pop && (held == 3'd1);
      over      = (SUM_W'(req_base) + SUM_W'(req_len)) > SUM_W'(DEPTH);
      wr_ok     = wr_en && (state_q == S_IDLE) && !req_valid &&
                  ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));
   end

   // Skid FIFO / in-flight next state; bank select follows the read it belongs to.
   always_comb begin
      cnt_d    = cnt_q + 2'(push) - 2'(fifo_pop);
      wptr_d   = wptr_q ^ push;
      rptr_d   = rptr_q ^ fifo_pop;
      infl_d   = issue;
      rd_sel_d = issue ? rd_addr_q[ADDR_W-1:ROW_W] : rd_sel_q;
   end

   // Output mux over the bank read registers, steered by the registered select.
   always_comb begin
      bank_data = '0;
      for (int b = 0; b < NUM_BANKS; b++)
         if (rd_sel_q == BANK_W'(b)) bank_data = bank_rd[b];
   end

   // Banks: one write port (program) and one synchronous read each.
   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [DATA_W-1:0] mem [BANK_DEPTH];
      logic [DATA_W-1:0] rd_q;
      // Program write and burst read for this bank.
      always_ff @(posedge clk) begin
         if (wr_ok && (wr_addr[ADDR_W-1:ROW_W] == BANK_W'(b)))
            mem[wr_addr[ROW_W-1:0]] <= wr_data;
         if (issue && (rd_addr_q[ADDR_W-1:ROW_W] == BANK_W'(b)))
            rd_q <= mem[rd_addr_q[ROW_W-1:0]];
      end
      assign bank_rd[b] = rd_q;
   end

   // Skid FIFO storage; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wptr_q] <= bank_data;
   end

   // Skid FIFO control and read-pipeline state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         infl_q   <= 1'b0;
         rd_sel_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         infl_q   <= infl_d;
         rd_sel_q <= rd_sel_d;
      end
   end

   // Burst FSM: IDLE accepts/rejects, FETCH issues reads, DRAIN waits for the last handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         rd_addr_q <= '0;
         rd_left_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: if (req_valid) begin
               if (over) begin
                  err_q  <= 1'b1;
                  done_q <= 1'b1;
               end else if (req_len == '0) begin
                  done_q <= 1'b1;
               end else begin
                  rd_addr_q <= req_base;
                  rd_left_q <= req_len;
                  state_q   <= S_FETCH;
               end
            end
            S_FETCH: if (issue) begin
               rd_addr_q <= rd_addr_q + 1'b1;
               rd_left_q <= rd_left_q - 1'b1;
               if (rd_left_q == LEN_W'(1)) state_q <= S_DRAIN;
            end
            S_DRAIN: if (last_hs) begin
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_bank_streamer.sv
// Directed bench for weight_bank_streamer: ramp preload, bursts with and
// without backpressure, bank crossing, range errors, reset mid-burst, writes.
module tb_weight_bank_streamer;

   localparam int DEPTH = 4296;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [12:0] req_base, req_len;
   logic        out_valid, out_ready;
   logic [7:0]  out_data;
   logic        done, err, busy;
   logic        wr_en;
   logic [12:0] wr_addr;
   logic [7:0]  wr_data;

   int total = 0;
   int bad   = 0;

   logic [7:0] got [$];
   int first_k, done_k, err_cnt;

   always #5 clk = ~clk;

   weight_bank_streamer dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base), .req_len(req_len),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .done(done), .err(err), .busy(busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called right after a falling edge: the request is seen at the next rising edge.
   task automatic send_req(input logic [12:0] b, input logic [12:0] l);
      req_valid = 1'b1;
      req_base  = b;
      req_len   = l;
   endtask

   // mode 0: always ready; mode 1: ready pattern 1-0-0-1 by cycle.
   // k counts cycles after the accept edge (k=1 is cycle T+1).
   task automatic collect(input int mode, input int abort_after, input int budget);
      logic       prev_v, prev_r, rdy;
      logic [7:0] prev_d;
      got.delete();
      first_k = -1; done_k = -1; err_cnt = 0;
      prev_v = 1'b0; prev_r = 1'b1; prev_d = '0;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         wr_en     = 1'b0;
         rdy = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
         out_ready = rdy;
         if (prev_v && !prev_r) begin
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_data", {24'b0, out_data}, {24'b0, prev_d});
         end
         if (out_valid && first_k < 0) first_k = k;
         if (err) err_cnt++;
         if (done) begin
            done_k = k;
            chk("done_vs_valid", {31'b0, out_valid}, 32'd0);
            return;
         end
         if (out_valid && rdy) got.push_back(out_data);
         prev_v = out_valid; prev_r = rdy; prev_d = out_data;
         if (abort_after > 0 && got.size() == abort_after) return;
      end
      total++;
      bad++;
      $error("FAIL timeout observed=no_done expected=done within %0d cycles", budget);
   endtask

   task automatic chk_ramp(input string tag, input int base, input int len);
      chk({tag, "_count"}, got.size(), len);
      for (int i = 0; i < got.size() && i < len; i++)
         chk({tag, "_data"}, {24'b0, got[i]}, {24'b0, 8'(base + i)});
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_base = '0; req_len = '0;
      out_ready = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_busy",      {31'b0, busy},      32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_done",      {31'b0, done},      32'd0);
      chk("rst_err",       {31'b0, err},       32'd0);
      rst = 1'b0;

      // Ramp preload mem[i] = i[7:0].
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         wr_en = 1'b1; wr_addr = 13'(i); wr_data = 8'(i);
      end
      @(negedge clk);
      wr_en = 1'b0;

      // Long back-to-back burst across banks 0..1.
      send_req(13'h0000, 13'd960);
      collect(0, 0, 3000);
      chk_ramp("t1", 0, 960);
      chk("t1_first_valid", first_k, 32'd2);
      chk("t1_done_cycle", done_k, 32'd962);
      chk("t1_err", err_cnt, 32'd0);

      // Bank 0/1 boundary, no bubble.
      send_req(13'h01FE, 13'd4);
      collect(0, 0, 100);
      chk_ramp("t2", 'h1FE, 4);
      chk("t2_done_cycle", done_k, 32'd6);

      // Backpressure 1-0-0-1.
      send_req(13'h03C0, 13'd216);
      collect(1, 0, 1200);
      chk_ramp("t3", 'h3C0, 216);

      // Range errors and the exact-fit boundary.
      send_req(13'h10C0, 13'd16);
      collect(0, 0, 50);
      chk("t4_err_done", done_k, 32'd1);
      chk("t4_err_pulse", err_cnt, 32'd1);
      chk("t4_err_words", got.size(), 32'd0);
      chk("t4_err_novalid", first_k, 32'hFFFF_FFFF);
      send_req(13'h1FFF, 13'h1FFF);
      collect(0, 0, 50);
      chk("t4_wrap_err", err_cnt, 32'd1);
      chk("t4_wrap_done", done_k, 32'd1);
      send_req(13'd4280, 13'd16);
      collect(0, 0, 100);
      chk_ramp("t4_fit", 4280, 16);
      chk("t4_fit_err", err_cnt, 32'd0);
      chk("t4_fit_done", done_k, 32'd18);
      send_req(13'h0000, 13'd0);
      collect(0, 0, 50);
      chk("t4_len0_done", done_k, 32'd1);
      chk("t4_len0_err", err_cnt, 32'd0);
      chk("t4_len0_words", got.size(), 32'd0);

      // Reset at word 100 of a 576-word burst.
      send_req(13'h0000, 13'd576);
      collect(0, 100, 2000);
      chk("t5_words_before", got.size(), 32'd100);
      rst = 1'b1;
      #1;
      chk("t5_valid_drop", {31'b0, out_valid}, 32'd0);
      chk("t5_busy_drop",  {31'b0, busy},      32'd0);
      chk("t5_ready",      {31'b0, req_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_no_done", {31'b0, done}, 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("t5_no_done_after", {31'b0, done}, 32'd0);
      send_req(13'h0100, 13'd8);
      collect(0, 0, 100);
      chk_ramp("t5_after", 'h100, 8);
      chk("t5_after_done", done_k, 32'd10);

      // Write while busy is ignored.
      out_ready = 1'b0;
      send_req(13'h0000, 13'd20);
      @(negedge clk);
      req_valid = 1'b0;
      wr_en = 1'b1; wr_addr = 13'd5; wr_data = 8'hA5;
      collect(0, 0, 200);
      chk("t6_busy_count", got.size(), 32'd20);
      if (got.size() > 5) chk("t6_busy_write", {24'b0, got[5]}, 32'h05);

      // Write in IDLE lands; write on an accept cycle does not.
      wr_en = 1'b1; wr_addr = 13'd5; wr_data = 8'hA5;
      @(negedge clk);
      wr_addr = 13'd6; wr_data = 8'h66;
      send_req(13'h0000, 13'd8);
      collect(0, 0, 100);
      chk("t6_idle_count", got.size(), 32'd8);
      if (got.size() == 8) begin
         chk("t6_idle_write", {24'b0, got[5]}, 32'hA5);
         chk("t6_accept_write", {24'b0, got[6]}, 32'h06);
         chk("t6_neighbour", {24'b0, got[4]}, 32'h04);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
